lift_seq: RTL

//  Sequential, lane-parallel lift of a ternary polynomial into Z_q for the NTRU KEM datapath.
//  - Mode 0 (HPS-style): plain lift, each coefficient mapped to Z_q.
//  - Mode 1 (HRSS-style): multiply by Phi_1 = (x-1) mod (q, x^N-1).

---
 rtl/lift_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/lift_seq.sv
// lift_seq: lifts a ternary polynomial into Z_q, LANES coefficients per clock,
// either plainly (mode 0) or multiplied by (x-1) mod (q, x^N-1) (mode 1).
module lift_seq #(
    parameter int N     = 700,
    parameter int LOGQ  = 13,
    parameter int LANES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [2*N-1:0]    m,
    output logic [LOGQ*N-1:0] m_sq,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int IW = $clog2(N + LANES + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic [2*N-1:0]  m_r;
    logic            mode_r;

    int              lane_j_s   [LANES];
    logic            lane_ok_s  [LANES];
    logic [1:0]      cur_s      [LANES];
    logic [1:0]      prv_s      [LANES];
    logic [LOGQ-1:0] lane_c_s   [LANES];
    logic            lane_inv_s;
    logic            last_s;

    // Digit to Z_q: +1 -> 1, -1 -> q-1, zero and invalid -> 0.
    function automatic logic [LOGQ-1:0] lift_digit(input logic [1:0] d);
        logic [LOGQ-1:0] v;
        case (d)
            2'b01:   v = {{(LOGQ-1){1'b0}}, 1'b1};
            2'b10:   v = {LOGQ{1'b1}};
            default: v = {LOGQ{1'b0}};
        endcase
        return v;
    endfunction

    // Per-lane coefficient for the current chunk; lane k handles index idx_r+k.
    always_comb begin
        lane_inv_s = 1'b0;
        last_s     = ((int'(idx_r) + LANES) >= N);
        for (int k = 0; k < LANES; k++) begin
            lane_j_s[k]  = int'(idx_r) + k;
            lane_ok_s[k] = (lane_j_s[k] < N);
            cur_s[k]     = 2'b00;
            prv_s[k]     = 2'b00;
            lane_c_s[k]  = {LOGQ{1'b0}};
            if (lane_ok_s[k]) begin
                cur_s[k] = m_r[2*lane_j_s[k] +: 2];
                // Coefficient 0 takes its predecessor from the top of the ring.
                if (lane_j_s[k] == 0) begin
                    prv_s[k] = m_r[2*N-1 -: 2];
                end else begin
                    prv_s[k] = m_r[2*lane_j_s[k]-2 +: 2];
                end
                if (mode_r) begin
                    lane_c_s[k] = lift_digit(prv_s[k]) - lift_digit(cur_s[k]);
                end else begin
                    lane_c_s[k] = lift_digit(cur_s[k]);
                end
                lane_inv_s = lane_inv_s | (cur_s[k] == 2'b11);
            end else begin
                lane_c_s[k] = {LOGQ{1'b0}};
            end
        end
    end

    // Control FSM, job-local operand copy and the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            m_r     <= '0;
            mode_r  <= 1'b0;
            m_sq    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        m_r     <= m;
                        mode_r  <= mode;
                        idx_r   <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < LANES; k++) begin
                        if (lane_ok_s[k]) begin
                            m_sq[LOGQ*lane_j_s[k] +: LOGQ] <= lane_c_s[k];
                        end
                    end
                    err <= err | lane_inv_s;
                    if (last_s) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IW'(LANES);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
